conv3x3_stream_ctrl: RTL
========================

# conv3x3_stream_ctrl

Parametrised streaming 3×3 convolution engine for the E203 accelerator datapath. It accepts a raster-ordered multi-channel pixel stream and keeps per-channel line buffers and window registers. It sums the channel-wise 3×3 MACs into one output channel, with frame geometry, channel count, fixed-point format and stride generalised. Row/column counters derive window validity, so no fixed output-count tables are needed. It sits between the input-feature-map DMA/FIFO and the output writeback path.

## Interface
- DW, 16, pixel/weight width, signed fixed point
- FRAC, 8, fractional bits of pixels, weights and output
- CH, 2, input channels (1..8)
- IMG_W, 6, frame width in pixels (≥3)
- IMG_H, 6, frame height in pixels (≥3)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin frame; honoured only in IDLE
- stride2  in  1  sampled at accepted start; 1 = stride 2, 0 = stride 1
- weight  in  CH*9*DW  kernels, channel c tap k at [(c*9+k)*DW +: DW]; tap k = 3*kr+kc, kr/kc 0 = oldest row/col; held stable while busy
- in_data  in  CH*DW  one pixel per channel, channel c at [c*DW +: DW]
- in_valid  in  1  in_data valid
- in_ready  out  1  high only in RUN
- out_data  out  DW  convolution result
- out_valid  out  1  single-cycle qualifier per result; no backpressure
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE: in_ready=0. start → RUN on the next edge; clear row/col to 0; latch stride2. in_valid is ignored.
- RUN: accept on in_valid&&in_ready. Each accept shifts pixels into the CH line buffers (depth 2*IMG_W) and the 3×3 window. col then increments. When col reaches IMG_W-1 it wraps to 0 and row increments.
- A window is valid on accept when row≥2 and col≥2. With stride2=1, (row-2) and (col-2) must also be even.
- Accepting pixel (IMG_H-1, IMG_W-1) moves the state to DRAIN.
- DRAIN: in_ready=0. Hold until the pipeline is empty (3 cycles), then pulse done and return to IDLE.
- start outside IDLE is ignored. start and in_valid together in IDLE accepts nothing that cycle.
- Arithmetic:
  - Products are signed 2*DW.
  - The accumulator is 2*DW+ceil(log2(9*CH)) bits and is exact.
  - Result = acc >>> FRAC (arithmetic, truncate toward −∞), saturated to [−2^(DW-1), 2^(DW-1)-1].
- Outputs per frame: (IMG_W-2)*(IMG_H-2) at stride 1; ceil((IMG_W-2)/2)*ceil((IMG_H-2)/2) at stride 2.
- in_valid gaps stall counters only. The pipeline advances every cycle, so outputs appear with matching gaps. Tag validity travels with the data.
- rst_n asserted mid-frame: immediate return to IDLE. All counters, pipeline tags, out_valid and done clear. The partial frame is discarded with no done pulse.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
- Pipeline:
  - accept edge N: window update
  - N+1: products registered
  - N+2: sum registered
  - N+3: out_data/out_valid registered
- Latency from the accepting edge to out_valid high is 3 clk. Throughput is one result per clk.
- out_data holds its last value when out_valid=0.
- done is high for exactly one cycle, in the cycle after the final out_valid cycle. busy drops in the same cycle as done.
- Minimum gap from done to the next accepted start is 0 cycles: start may be asserted during the done cycle, since the state is already IDLE.

## Configuration
- CONV_RELU_EN defined: results are clamped at 0 after saturation, so out_data ≥ 0.
- CONV_RELU_EN undefined: signed saturated result passes unchanged; no ReLU logic is instantiated.

## Test plan
- Default params, stride2=0, all pixels 0x0100 (1.0), all weights 0x0100, in_valid held high → 16 outputs, each 0x1200 (18.0). First output 3 clk after accepting pixel (2,2). done pulses 1 cycle after the 16th output.
- Same frame with stride2=1 → exactly 4 outputs, for windows at (2,2),(2,4),(4,2),(4,4), each 0x1200.
- Pixels 0x7FFF and weights 0x7FFF → every output 0x7FFF. Weights 0x8000 (−128.0) → 0x8000, or 0x0000 with CONV_RELU_EN.
- Ramp pixel value = row*IMG_W+col; ch0 centre tap 0x0100, all other taps 0 → outputs equal the centre pixel of each window: 7,8,9,10,13,… Apply random in_valid gaps → identical output sequence.
- Assert rst_n low after 20 accepts → out_valid/busy/in_ready go to 0 immediately with no done pulse. A subsequent full frame is correct.
- start pulsed during RUN and during DRAIN → ignored, output count unchanged. start in the done cycle → the next frame starts cleanly.

Source files
------------

// File: rtl/conv3x3_stream_ctrl.sv
// Streaming 3x3 multi-channel convolution engine.
// It takes a raster-ordered pixel stream with CH channels and produces one
// output channel by summing the per-channel 3x3 MACs.
// Window validity comes from row/col counters. The datapath pipeline is
// accept -> products -> sum -> out.
// Optional feature: define CONV_RELU_EN to clamp saturated results at zero.
module conv3x3_stream_ctrl #(
    parameter int unsigned DW    = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned CH    = 2,
    parameter int unsigned IMG_W = 6,
    parameter int unsigned IMG_H = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stride2,
    input  logic [CH*9*DW-1:0]   weight,
    input  logic [CH*DW-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned NTAP = 9 * CH;
    localparam int unsigned PW   = 2 * DW;
    localparam int unsigned AW   = 2 * DW + $clog2(NTAP);
    localparam int unsigned CW   = $clog2(IMG_W);
    localparam int unsigned RW   = $clog2(IMG_H);
    localparam int unsigned LBD  = 2 * IMG_W;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   col, col_nxt;
    logic [RW-1:0]   row, row_nxt;
    logic            s2_q, s2_nxt;
    logic [1:0]      dcnt, dcnt_nxt;
    logic            done_nxt;
    logic            win_vld_nxt;
    logic            accept;

    // validity tags that travel alongside the datapath stages
    logic            v0, v1, v2;

    logic signed [DW-1:0] lb   [CH][LBD];
    logic signed [DW-1:0] win  [CH][9];
    logic signed [PW-1:0] prod [NTAP];
    logic signed [AW-1:0] sum_c;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] sh_c;
    logic [DW-1:0]        res_c;

    assign accept = in_valid && in_ready;

    // next-state, counter and window-validity decode
    always_comb begin
        state_nxt   = state;
        col_nxt     = col;
        row_nxt     = row;
        s2_nxt      = s2_q;
        dcnt_nxt    = dcnt;
        done_nxt    = 1'b0;
        win_vld_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    col_nxt   = '0;
                    row_nxt   = '0;
                    s2_nxt    = stride2;
                end
            end
            S_RUN: begin
                if (accept) begin
                    // row-2 / col-2 even is the same as row / col even
                    win_vld_nxt = (row >= RW'(2)) && (col >= CW'(2)) &&
                                  (!s2_q || (!row[0] && !col[0]));
                    if (col == CW'(IMG_W - 1)) begin
                        col_nxt = '0;
                        row_nxt = row + RW'(1);
                        if (row == RW'(IMG_H - 1)) begin
                            state_nxt = S_DRAIN;
                            dcnt_nxt  = '0;
                        end
                    end else begin
                        col_nxt = col + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // done lands one cycle after the last in-flight result
                if (dcnt == 2'd3) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    dcnt_nxt = dcnt + 2'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // counters, control outputs and pipeline tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            s2_q      <= 1'b0;
            dcnt      <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            col       <= col_nxt;
            row       <= row_nxt;
            s2_q      <= s2_nxt;
            dcnt      <= dcnt_nxt;
            in_ready  <= (state_nxt == S_RUN);
            busy      <= (state_nxt != S_IDLE);
            done      <= done_nxt;
            v0        <= win_vld_nxt;
            v1        <= v0;
            v2        <= v1;
            out_valid <= v2;
            if (v2) begin
                out_data <= res_c;
            end
        end
    end

    // line buffers and 3x3 windows; tap 8 is the newest pixel
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int ch = 0; ch < int'(CH); ch++) begin
                win[ch][8] <= $signed(in_data[ch*DW +: DW]);
                win[ch][7] <= win[ch][8];
                win[ch][6] <= win[ch][7];
                win[ch][5] <= lb[ch][IMG_W-1];
                win[ch][4] <= win[ch][5];
                win[ch][3] <= win[ch][4];
                win[ch][2] <= lb[ch][LBD-1];
                win[ch][1] <= win[ch][2];
                win[ch][0] <= win[ch][1];
                lb[ch][0]  <= $signed(in_data[ch*DW +: DW]);
                for (int j = 1; j < int'(LBD); j++) begin
                    lb[ch][j] <= lb[ch][j-1];
                end
            end
        end
    end

    // stage 1: per-tap signed products
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < int'(CH); ch++) begin
            for (int k = 0; k < 9; k++) begin
                prod[ch*9+k] <= PW'(win[ch][k]) * PW'($signed(weight[(ch*9+k)*DW +: DW]));
            end
        end
    end

    // exact adder tree over all taps of all channels
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(NTAP); i++) begin
            sum_c = sum_c + AW'(prod[i]);
        end
    end

    // stage 2: registered sum
    always_ff @(posedge clk) begin
        acc_q <= sum_c;
    end

    // rescale, saturate and optional ReLU clamp
    always_comb begin
        sh_c = acc_q >>> FRAC;
        if (sh_c > SAT_MAX) begin
            res_c = SAT_MAX[DW-1:0];
        end else if (sh_c < SAT_MIN) begin
            res_c = SAT_MIN[DW-1:0];
        end else begin
            res_c = sh_c[DW-1:0];
        end
`ifdef CONV_RELU_EN
        if (res_c[DW-1]) begin
            res_c = '0;
        end
`else
`endif
    end

endmodule
